// File: rtl/multi_chan_acq_sequencer_if.sv
// Event FIFO write handshake between the acquisition sequencer and the event FIFO.
// The sequencer drives valid/data; the FIFO drives ready.
interface multi_chan_acq_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              fifo_valid;
  logic              fifo_ready;
  logic [DATA_W-1:0] fifo_data;

  modport master (output fifo_valid, output fifo_data, input fifo_ready);
  modport slave  (input fifo_valid, input fifo_data, output fifo_ready);
endinterface

// File: rtl/multi_chan_acq_sequencer.sv
// Trigger sequencer: delays an accepted TTC trigger, fans it out to NCHAN channels,
// waits for done or timeout, then writes one event-info word to the event FIFO.
module multi_chan_acq_sequencer #(
  parameter int NCHAN     = 5,
  parameter int DELAY_W   = 4,
  parameter int TYPE_W    = 2,
  parameter int NUM_W     = 24,
  parameter int TIMEOUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCHAN-1:0]        chan_en,
  input  logic [DELAY_W-1:0]      trig_delay,
  input  logic [TIMEOUT_W-1:0]    acq_timeout,
  input  logic                    trigger,
  input  logic [TYPE_W-1:0]       trig_type,
  input  logic [NUM_W-1:0]        trig_num,
  input  logic [NCHAN-1:0]        acq_done,
  output logic [TYPE_W*NCHAN-1:0] acq_enable,
  output logic [NCHAN-1:0]        acq_trig,
  multi_chan_acq_sequencer_if.master fifo,
  output logic [15:0]             trig_dropped,
  output logic [3:0]              state
);

  localparam int FIFO_W = 1 + NCHAN + TYPE_W + NUM_W;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_DELAY = 4'b0010,
    S_FILL  = 4'b0100,
    S_STORE = 4'b1000
  } state_e;

  state_e                    state_q,      state_d;
  logic [NCHAN-1:0]          en_l_q,       en_l_d;
  logic [DELAY_W-1:0]        dly_l_q,      dly_l_d;
  logic [TYPE_W-1:0]         type_l_q,     type_l_d;
  logic [NUM_W-1:0]          num_l_q,      num_l_d;
  logic [NCHAN-1:0]          done_seen_q,  done_seen_d;
  logic [DELAY_W-1:0]        dly_cnt_q,    dly_cnt_d;
  logic [TIMEOUT_W-1:0]      fill_cnt_q,   fill_cnt_d;
  logic [FIFO_W-1:0]         fifo_data_q,  fifo_data_d;
  logic                      fifo_valid_q, fifo_valid_d;
  logic [NCHAN-1:0]          acq_trig_q,   acq_trig_d;
  logic [TYPE_W*NCHAN-1:0]   acq_enable_q, acq_enable_d;
  logic [15:0]               dropped_q,    dropped_d;

  logic [NCHAN-1:0]          seen_now;
  logic [TIMEOUT_W:0]        fill_cnt_inc;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d     = state_q;
    en_l_d      = en_l_q;
    dly_l_d     = dly_l_q;
    type_l_d    = type_l_q;
    num_l_d     = num_l_q;
    done_seen_d = done_seen_q;
    dly_cnt_d   = dly_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    fifo_data_d = fifo_data_q;
    dropped_d   = dropped_q;

    seen_now     = done_seen_q | (acq_done & en_l_q);
    fill_cnt_inc = {1'b0, fill_cnt_q} + (TIMEOUT_W+1)'(1);

    if (trigger && (state_q != S_IDLE) && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          en_l_d      = chan_en;
          dly_l_d     = trig_delay;
          type_l_d    = trig_type;
          num_l_d     = trig_num;
          done_seen_d = '0;
          dly_cnt_d   = '0;
          fill_cnt_d  = '0;
          if (chan_en == '0) begin
            state_d     = S_STORE;
            fifo_data_d = {1'b0, {NCHAN{1'b0}}, trig_type, trig_num};
          end else if (trig_delay != '0) begin
            state_d = S_DELAY;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_DELAY: begin
        if (dly_cnt_q == dly_l_q - DELAY_W'(1)) begin
          state_d = S_FILL;
        end else begin
          dly_cnt_d = dly_cnt_q + DELAY_W'(1);
        end
      end

      S_FILL: begin
        done_seen_d = seen_now;
        if (fill_cnt_q != '1) begin
          fill_cnt_d = fill_cnt_q + TIMEOUT_W'(1);
        end
        // Completion wins over a timeout landing in the same cycle.
        if (seen_now == en_l_q) begin
          state_d     = S_STORE;
          fifo_data_d = {1'b0, {NCHAN{1'b0}}, type_l_q, num_l_q};
        end else if ((acq_timeout != '0) && (fill_cnt_inc >= {1'b0, acq_timeout})) begin
          state_d     = S_STORE;
          fifo_data_d = {1'b1, en_l_q & ~seen_now, type_l_q, num_l_q};
        end
      end

      S_STORE: begin
        if (fifo.fifo_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values, so they never see inputs directly.
    fifo_valid_d = (state_d == S_STORE);
    acq_trig_d   = (state_d == S_FILL) ? (en_l_d & ~done_seen_d) : '0;
    acq_enable_d = (state_d == S_FILL) ? {NCHAN{type_l_d}} : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      en_l_q       <= '0;
      dly_l_q      <= '0;
      type_l_q     <= '0;
      num_l_q      <= '0;
      done_seen_q  <= '0;
      dly_cnt_q    <= '0;
      fill_cnt_q   <= '0;
      fifo_data_q  <= '0;
      fifo_valid_q <= 1'b0;
      acq_trig_q   <= '0;
      acq_enable_q <= '0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      en_l_q       <= en_l_d;
      dly_l_q      <= dly_l_d;
      type_l_q     <= type_l_d;
      num_l_q      <= num_l_d;
      done_seen_q  <= done_seen_d;
      dly_cnt_q    <= dly_cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      fifo_data_q  <= fifo_data_d;
      fifo_valid_q <= fifo_valid_d;
      acq_trig_q   <= acq_trig_d;
      acq_enable_q <= acq_enable_d;
      dropped_q    <= dropped_d;
    end
  end

  assign state           = state_q;
  assign acq_trig        = acq_trig_q;
  assign acq_enable      = acq_enable_q;
  assign trig_dropped    = dropped_q;
  assign fifo.fifo_valid = fifo_valid_q;
  assign fifo.fifo_data  = fifo_data_q;

endmodule

// File: tb/tb_multi_chan_acq_sequencer.sv
// Directed bench for multi_chan_acq_sequencer: table of event scenarios plus
// hand-written backpressure, reset-abort and drop-saturation sequences.
module tb_multi_chan_acq_sequencer;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_DELAY = 4'b0010;
  localparam logic [3:0] ST_FILL  = 4'b0100;
  localparam logic [3:0] ST_STORE = 4'b1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  chan_en;
  logic [3:0]  trig_delay;
  logic [15:0] acq_timeout;
  logic        trigger;
  logic [1:0]  trig_type;
  logic [23:0] trig_num;
  logic [4:0]  acq_done;
  logic [9:0]  acq_enable;
  logic [4:0]  acq_trig;
  logic [15:0] trig_dropped;
  logic [3:0]  state;

  multi_chan_acq_sequencer_if #(.DATA_W(32)) fifo_if ();

  multi_chan_acq_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .chan_en      (chan_en),
    .trig_delay   (trig_delay),
    .acq_timeout  (acq_timeout),
    .trigger      (trigger),
    .trig_type    (trig_type),
    .trig_num     (trig_num),
    .acq_done     (acq_done),
    .acq_enable   (acq_enable),
    .acq_trig     (acq_trig),
    .fifo         (fifo_if),
    .trig_dropped (trig_dropped),
    .state        (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int words    = 0;

  always @(posedge clk) begin
    if (!reset && fifo_if.fifo_valid && fifo_if.fifo_ready) words <= words + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // done_at[i] = FILL cycle index in which channel i pulses done; 15 = never.
  typedef struct packed {
    logic [4:0]      en;
    logic [3:0]      dly;
    logic [1:0]      typ;
    logic [23:0]     num;
    logic [15:0]     tmo;
    logic [4:0][3:0] done_at;
    int              exp_entry;
    int              exp_fill;
    logic [9:0]      exp_en;
    logic [31:0]     exp_data;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  initial begin
    int n;
    int k;
    int words_before;
    logic [4:0] exp_trig;

    vecs[0] = '{en:5'b11111, dly:4'd0,  typ:2'd2, num:24'h000123, tmo:16'd0,
                done_at:{4'd3,4'd3,4'd3,4'd3,4'd3}, exp_entry:1, exp_fill:4,
                exp_en:10'b1010101010, exp_data:32'h02000123};
    vecs[1] = '{en:5'b11111, dly:4'd4,  typ:2'd1, num:24'h000456, tmo:16'd0,
                done_at:{4'd0,4'd0,4'd0,4'd0,4'd0}, exp_entry:5, exp_fill:1,
                exp_en:10'b0101010101, exp_data:32'h01000456};
    vecs[2] = '{en:5'b10101, dly:4'd2,  typ:2'd3, num:24'h0000AA, tmo:16'd0,
                done_at:{4'd7,4'd15,4'd4,4'd15,4'd1}, exp_entry:3, exp_fill:8,
                exp_en:10'b1111111111, exp_data:32'h030000AA};
    vecs[3] = '{en:5'b01111, dly:4'd1,  typ:2'd1, num:24'd7,      tmo:16'd10,
                done_at:{4'd15,4'd15,4'd2,4'd2,4'd2}, exp_entry:2, exp_fill:10,
                exp_en:10'b0101010101, exp_data:32'hA1000007};
    vecs[4] = '{en:5'b00000, dly:4'd3,  typ:2'd3, num:24'hABCDEF, tmo:16'd0,
                done_at:{4'd15,4'd15,4'd15,4'd15,4'd15}, exp_entry:1, exp_fill:0,
                exp_en:10'b0, exp_data:32'h03ABCDEF};
    vecs[5] = '{en:5'b00011, dly:4'd1,  typ:2'd2, num:24'h000055, tmo:16'd3,
                done_at:{4'd0,4'd0,4'd0,4'd2,4'd1}, exp_entry:2, exp_fill:3,
                exp_en:10'b1010101010, exp_data:32'h02000055};
    vecs[6] = '{en:5'b00001, dly:4'd15, typ:2'd0, num:24'hFFFFFF, tmo:16'd0,
                done_at:{4'd15,4'd15,4'd15,4'd15,4'd0}, exp_entry:16, exp_fill:1,
                exp_en:10'b0, exp_data:32'h00FFFFFF};
    vecs[7] = '{en:5'b11000, dly:4'd0,  typ:2'd2, num:24'h000010, tmo:16'd5,
                done_at:{4'd15,4'd1,4'd15,4'd15,4'd15}, exp_entry:1, exp_fill:5,
                exp_en:10'b1010101010, exp_data:32'hC2000010};

    reset = 1'b1; chan_en = '0; trig_delay = '0; acq_timeout = '0; trigger = 1'b0;
    trig_type = '0; trig_num = '0; acq_done = '0; fifo_if.fifo_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_state",      32'(state),              32'(ST_IDLE));
    check("reset_fifo_valid", 32'(fifo_if.fifo_valid), 32'd0);
    check("reset_fifo_data",  fifo_if.fifo_data,       32'd0);
    check("reset_acq_trig",   32'(acq_trig),           32'd0);
    check("reset_acq_enable", 32'(acq_enable),         32'd0);
    check("reset_dropped",    32'(trig_dropped),       32'd0);

    for (int v = 0; v < NVEC; v++) begin
      chan_en = vecs[v].en; trig_delay = vecs[v].dly; trig_type = vecs[v].typ;
      trig_num = vecs[v].num; acq_timeout = vecs[v].tmo; trigger = 1'b1;
      tick();
      // Scramble live inputs: the event in flight must use the latched copies.
      trigger = 1'b0; trig_delay = 4'd9; chan_en = ~vecs[v].en;
      trig_type = ~vecs[v].typ; trig_num = ~vecs[v].num;
      n = 1;
      while (state == ST_DELAY && n < 40) begin
        tick();
        n++;
      end
      check($sformatf("v%0d_entry_cycles", v), 32'(n), 32'(vecs[v].exp_entry));
      if (vecs[v].exp_fill > 0) begin
        check($sformatf("v%0d_fill_state", v), 32'(state), 32'(ST_FILL));
        check($sformatf("v%0d_acq_enable", v), 32'(acq_enable), 32'(vecs[v].exp_en));
      end
      k = 0;
      while (state == ST_FILL && k < 40) begin
        exp_trig = '0;
        for (int i = 0; i < 5; i++) begin
          acq_done[i] = (int'(vecs[v].done_at[i]) == k);
          exp_trig[i] = vecs[v].en[i] && !(int'(vecs[v].done_at[i]) < k);
        end
        check($sformatf("v%0d_acq_trig_c%0d", v, k), 32'(acq_trig), 32'(exp_trig));
        tick();
        k++;
      end
      acq_done = '0;
      check($sformatf("v%0d_fill_cycles", v), 32'(k), 32'(vecs[v].exp_fill));
      check($sformatf("v%0d_store_state", v), 32'(state), 32'(ST_STORE));
      check($sformatf("v%0d_fifo_valid", v), 32'(fifo_if.fifo_valid), 32'd1);
      check($sformatf("v%0d_fifo_data", v), fifo_if.fifo_data, vecs[v].exp_data);
      check($sformatf("v%0d_store_acq_trig", v), 32'(acq_trig), 32'd0);
      fifo_if.fifo_ready = 1'b1;
      tick();
      fifo_if.fifo_ready = 1'b0;
      check($sformatf("v%0d_idle_state", v), 32'(state), 32'(ST_IDLE));
      check($sformatf("v%0d_idle_valid", v), 32'(fifo_if.fifo_valid), 32'd0);
    end
    check("table_words", 32'(words), 32'(NVEC));
    check("table_dropped", 32'(trig_dropped), 32'd0);

    // Backpressure with drops in DELAY, FILL and the STORE transfer cycle.
    words_before = words;
    chan_en = 5'b00001; trig_delay = 4'd2; trig_type = 2'd1; trig_num = 24'h000321;
    acq_timeout = '0; trigger = 1'b1;
    tick();
    check("bp_delay_state", 32'(state), 32'(ST_DELAY));
    tick();                        // trigger still high: dropped in DELAY
    trigger = 1'b0;
    tick();
    check("bp_fill_state", 32'(state), 32'(ST_FILL));
    trigger = 1'b1;
    tick();                        // dropped in FILL
    trigger = 1'b0; acq_done = 5'b00001;
    tick();
    acq_done = '0;
    check("bp_store_state", 32'(state), 32'(ST_STORE));
    for (int c = 0; c < 20; c++) begin
      check($sformatf("bp_valid_c%0d", c), 32'(fifo_if.fifo_valid), 32'd1);
      check($sformatf("bp_data_c%0d", c), fifo_if.fifo_data, 32'h01000321);
      tick();
    end
    fifo_if.fifo_ready = 1'b1; trigger = 1'b1;
    tick();                        // transfer cycle trigger is dropped too
    fifo_if.fifo_ready = 1'b0; trigger = 1'b0;
    check("bp_idle_state", 32'(state), 32'(ST_IDLE));
    check("bp_idle_valid", 32'(fifo_if.fifo_valid), 32'd0);
    check("bp_dropped", 32'(trig_dropped), 32'd3);
    check("bp_one_word", 32'(words - words_before), 32'd1);

    // Next trigger is accepted; then reset aborts it mid-FILL.
    chan_en = 5'b00001; trig_delay = 4'd0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("next_accepted", 32'(state), 32'(ST_FILL));
    check("next_not_counted", 32'(trig_dropped), 32'd3);
    words_before = words;
    tick(); tick();
    check("mid_fill_state", 32'(state), 32'(ST_FILL));
    check("mid_fill_trig", 32'(acq_trig), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_state", 32'(state), 32'(ST_IDLE));
    check("abort_acq_trig", 32'(acq_trig), 32'd0);
    check("abort_valid", 32'(fifo_if.fifo_valid), 32'd0);
    check("abort_dropped", 32'(trig_dropped), 32'd0);
    reset = 1'b0;
    fifo_if.fifo_ready = 1'b1;
    repeat (5) tick();
    fifo_if.fifo_ready = 1'b0;
    check("abort_no_word", 32'(words - words_before), 32'd0);
    check("abort_idle", 32'(state), 32'(ST_IDLE));

    // Drop counter saturation: hold STORE under backpressure, trigger every cycle.
    chan_en = 5'b00000; trigger = 1'b1;
    tick();
    check("sat_store_state", 32'(state), 32'(ST_STORE));
    repeat (70000) tick();
    trigger = 1'b0;
    tick();
    check("sat_dropped", 32'(trig_dropped), 32'h0000FFFF);
    check("sat_valid_held", 32'(fifo_if.fifo_valid), 32'd1);
    fifo_if.fifo_ready = 1'b1;
    tick();
    fifo_if.fifo_ready = 1'b0;
    check("sat_idle", 32'(state), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
